// File: rtl/tcbm_device_link.sv
// tcbm_device_link
// Device-side (drive-end) TCBM handshake engine. Each host transfer is two
// 4-phase DAV/ACK handshakes: a code byte followed by one data byte.
//   code 0x81 : host writes a command byte  -> rx stream, rx_is_cmd=1
//   code 0x82 : host writes a data byte     -> rx stream, rx_is_cmd=0
//   code 0x83 : host reads a byte           <- tx stream (tx_data/tx_status)
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   dav_in, pa_in         asynchronous host DAV and port A pins
//   pa_out, pa_oe         port A drive value / drive enable
//   ack_out, status_out   handshake ACK and 2 status pins to host
//   rx_valid/rx_ready/rx_data/rx_is_cmd   byte stream to the core
//   dev_status            status returned for 0x81/0x82 transfers
//   tx_valid/tx_data/tx_status/tx_ready   byte offered by the core for 0x83
//   err_code, err_timeout single-cycle error pulses
module tcbm_device_link #(
    parameter int SYNC_STAGES    = 2,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dav_in,
    input  logic [7:0] pa_in,
    output logic [7:0] pa_out,
    output logic       pa_oe,
    output logic       ack_out,
    output logic [1:0] status_out,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_is_cmd,
    input  logic       rx_ready,
    input  logic [1:0] dev_status,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic [1:0] tx_status,
    output logic       tx_ready,
    output logic       err_code,
    output logic       err_timeout
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CODE, ST_CODE_REL, ST_RX_DAV,
        ST_RX_HOLD, ST_TX_WAIT, ST_TX_SET, ST_FIN
    } state_t;

    function automatic logic code_known(input logic [7:0] c);
        return (c == 8'h81) || (c == 8'h82) || (c == 8'h83);
    endfunction

    state_t            state_r, state_s;
    logic [SYNC_STAGES-1:0] dav_sync_r;
    logic [7:0]        pa_sync_r [SYNC_STAGES];
    logic              dav_s;
    logic [7:0]        pa_s;

    logic [7:0]        code_r, code_s;
    logic [SW-1:0]     settle_r, settle_s;
    logic [TW-1:0]     to_cnt_r, to_cnt_s;
    logic              armed_r, armed_s;
    logic              to_count_s;

    logic [7:0]        pa_out_r, pa_out_s;
    logic              pa_oe_r, pa_oe_s;
    logic              ack_r, ack_s;
    logic [1:0]        status_r, status_s;
    logic              rx_valid_r, rx_valid_s;
    logic [7:0]        rx_data_r, rx_data_s;
    logic              rx_is_cmd_r, rx_is_cmd_s;
    logic              tx_ready_r, tx_ready_s;
    logic              err_code_r, err_code_s;
    logic              err_to_r, err_to_s;

    // Input synchronisers; deliberately not reset so a DAV held high across
    // reset is still seen as high and cannot fake a fresh 0->1 edge.
    always_ff @(posedge clock) begin
        dav_sync_r   <= {dav_sync_r[SYNC_STAGES-2:0], dav_in};
        pa_sync_r[0] <= pa_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            pa_sync_r[i] <= pa_sync_r[i-1];
        end
    end

    assign dav_s = dav_sync_r[SYNC_STAGES-1];
    assign pa_s  = pa_sync_r[SYNC_STAGES-1];

    // Next-state and next-output logic for the handshake engine.
    always_comb begin
        state_s     = state_r;
        code_s      = code_r;
        settle_s    = settle_r;
        pa_out_s    = pa_out_r;
        pa_oe_s     = pa_oe_r;
        ack_s       = ack_r;
        status_s    = status_r;
        rx_valid_s  = rx_valid_r;
        rx_data_s   = rx_data_r;
        rx_is_cmd_s = rx_is_cmd_r;
        tx_ready_s  = 1'b0;
        err_code_s  = 1'b0;
        err_to_s    = 1'b0;
        // A new code is only accepted once DAV has been observed low.
        armed_s     = armed_r | ~dav_s;
        to_count_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                pa_oe_s = 1'b0;
                ack_s   = 1'b0;
                if (dav_s && armed_r) begin
                    state_s  = ST_CODE;
                    code_s   = pa_s;
                    settle_s = '0;
                    if (!code_known(pa_s)) begin
                        err_code_s = 1'b1;
                        status_s   = 2'b11;
                    end else begin
                        status_s = status_r;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CODE: begin
                if (settle_r == SW'(SETTLE_CYCLES - 1)) begin
                    ack_s   = 1'b1;
                    state_s = ST_CODE_REL;
                end else begin
                    settle_s = settle_r + 1'b1;
                end
            end
            ST_CODE_REL: begin
                to_count_s = 1'b1;
                if (!dav_s) begin
                    ack_s = 1'b0;
                    if (!code_known(code_r)) begin
                        state_s = ST_IDLE;
                    end else if (code_r == 8'h83) begin
                        state_s = ST_TX_WAIT;
                    end else begin
                        state_s = ST_RX_DAV;
                    end
                end else begin
                    state_s = ST_CODE_REL;
                end
            end
            ST_RX_DAV: begin
                to_count_s = 1'b1;
                if (dav_s) begin
                    rx_data_s   = pa_s;
                    rx_valid_s  = 1'b1;
                    rx_is_cmd_s = (code_r == 8'h81);
                    settle_s    = '0;
                    state_s     = ST_RX_HOLD;
                end else begin
                    state_s = ST_RX_DAV;
                end
            end
            ST_RX_HOLD: begin
                // While rx_valid is up we wait on the core; afterwards the
                // settle counter runs from the cycle status_out was updated.
                if (rx_valid_r) begin
                    if (rx_ready) begin
                        rx_valid_s = 1'b0;
                        status_s   = dev_status;
                        settle_s   = '0;
                    end else begin
                        rx_valid_s = 1'b1;
                    end
                end else if (settle_r == SW'(SETTLE_CYCLES - 1)) begin
                    ack_s   = 1'b1;
                    state_s = ST_FIN;
                end else begin
                    settle_s = settle_r + 1'b1;
                end
            end
            ST_TX_WAIT: begin
                to_count_s = ~dav_s;
                if (dav_s && tx_valid) begin
                    pa_out_s   = tx_data;
                    status_s   = tx_status;
                    pa_oe_s    = 1'b1;
                    tx_ready_s = 1'b1;
                    settle_s   = '0;
                    state_s    = ST_TX_SET;
                end else begin
                    state_s = ST_TX_WAIT;
                end
            end
            ST_TX_SET: begin
                if (settle_r == SW'(SETTLE_CYCLES - 1)) begin
                    ack_s   = 1'b1;
                    state_s = ST_FIN;
                end else begin
                    settle_s = settle_r + 1'b1;
                end
            end
            ST_FIN: begin
                to_count_s = 1'b1;
                if (!dav_s) begin
                    pa_oe_s = 1'b0;
                    ack_s   = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_FIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
                ack_s   = 1'b0;
                pa_oe_s = 1'b0;
            end
        endcase

        // Timeout counter: cleared on every state change, counts only in
        // the host-wait states. Expiry aborts the transfer and disarms so a
        // stuck-high DAV is not taken as a new code byte.
        if (state_s != state_r) begin
            to_cnt_s = '0;
        end else if (to_count_s) begin
            if (to_cnt_r == TW'(TIMEOUT_CYCLES - 1)) begin
                to_cnt_s   = '0;
                err_to_s   = 1'b1;
                ack_s      = 1'b0;
                pa_oe_s    = 1'b0;
                rx_valid_s = 1'b0;
                armed_s    = 1'b0;
                state_s    = ST_IDLE;
            end else begin
                to_cnt_s = to_cnt_r + 1'b1;
            end
        end else begin
            to_cnt_s = to_cnt_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            code_r      <= 8'h00;
            settle_r    <= '0;
            to_cnt_r    <= '0;
            armed_r     <= 1'b0;
            pa_out_r    <= 8'h00;
            pa_oe_r     <= 1'b0;
            ack_r       <= 1'b0;
            status_r    <= 2'b00;
            rx_valid_r  <= 1'b0;
            rx_data_r   <= 8'h00;
            rx_is_cmd_r <= 1'b0;
            tx_ready_r  <= 1'b0;
            err_code_r  <= 1'b0;
            err_to_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            code_r      <= code_s;
            settle_r    <= settle_s;
            to_cnt_r    <= to_cnt_s;
            armed_r     <= armed_s;
            pa_out_r    <= pa_out_s;
            pa_oe_r     <= pa_oe_s;
            ack_r       <= ack_s;
            status_r    <= status_s;
            rx_valid_r  <= rx_valid_s;
            rx_data_r   <= rx_data_s;
            rx_is_cmd_r <= rx_is_cmd_s;
            tx_ready_r  <= tx_ready_s;
            err_code_r  <= err_code_s;
            err_to_r    <= err_to_s;
        end
    end

    assign pa_out      = pa_out_r;
    assign pa_oe       = pa_oe_r;
    assign ack_out     = ack_r;
    assign status_out  = status_r;
    assign rx_valid    = rx_valid_r;
    assign rx_data     = rx_data_r;
    assign rx_is_cmd   = rx_is_cmd_r;
    assign tx_ready    = tx_ready_r;
    assign err_code    = err_code_r;
    assign err_timeout = err_to_r;

endmodule

// File: tb/tb_tcbm_device_link.sv
// Directed bench for tcbm_device_link: plays the host side of the TCBM
// handshake and checks results against hand-computed values.
module tb_tcbm_device_link;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 64;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       dav_in = 1'b0;
    logic [7:0] pa_in = 8'h00;
    logic [7:0] pa_out;
    logic       pa_oe, ack_out;
    logic [1:0] status_out;
    logic       rx_valid, rx_is_cmd, tx_ready, err_code, err_timeout;
    logic [7:0] rx_data;
    logic       rx_ready = 1'b1;
    logic [1:0] dev_status = 2'b00;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [1:0] tx_status = 2'b00;

    int tests_run = 0;
    int tests_failed = 0;

    // Bookkeeping updated once per clock inside tick().
    logic [1:0] prev_st = 2'b00;
    logic [7:0] prev_pa = 8'h00;
    logic       prev_ack = 1'b0, prev_rxv = 1'b0;
    int         since = 0, ack_since = -1;
    int         rx_cnt = 0, tx_cnt = 0, ec_cnt = 0, et_cnt = 0;
    logic [7:0] rx_seen = 8'h00;
    logic       rx_cmd_seen = 1'b0;

    tcbm_device_link #(.SYNC_STAGES(2), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .dav_in(dav_in), .pa_in(pa_in),
        .pa_out(pa_out), .pa_oe(pa_oe), .ack_out(ack_out), .status_out(status_out),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_is_cmd(rx_is_cmd), .rx_ready(rx_ready),
        .dev_status(dev_status), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_status(tx_status), .tx_ready(tx_ready), .err_code(err_code),
        .err_timeout(err_timeout)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (status_out != prev_st || pa_out != prev_pa) since = 0;
        else since++;
        if (ack_out && !prev_ack) ack_since = since;
        if (rx_valid && !prev_rxv) begin
            rx_cnt++;
            rx_seen = rx_data;
            rx_cmd_seen = rx_is_cmd;
        end
        if (tx_ready) tx_cnt++;
        if (err_code) ec_cnt++;
        if (err_timeout) et_cnt++;
        prev_st = status_out;
        prev_pa = pa_out;
        prev_ack = ack_out;
        prev_rxv = rx_valid;
    endtask

    task automatic wait_ack(input string tag, input logic lvl);
        int n = 0;
        while (ack_out !== lvl && n < 300) begin
            tick();
            n++;
        end
        check_eq(tag, 16'(ack_out), 16'(lvl));
    endtask

    task automatic host_byte(input string tag, input logic [7:0] b);
        pa_in = b;
        dav_in = 1'b1;
        wait_ack({tag, "_ack1"}, 1'b1);
        dav_in = 1'b0;
        wait_ack({tag, "_ack0"}, 1'b0);
    endtask

    initial begin
        int n, hi, ec0;

        // Reset state
        repeat (5) tick();
        check_eq("rst_ack", 16'(ack_out), 16'd0);
        check_eq("rst_oe", 16'(pa_oe), 16'd0);
        check_eq("rst_pa", 16'(pa_out), 16'h0);
        check_eq("rst_st", 16'(status_out), 16'd0);
        check_eq("rst_rxv", 16'(rx_valid), 16'd0);
        check_eq("rst_err", 16'({err_code, err_timeout, tx_ready}), 16'd0);
        reset = 1'b0;
        repeat (3) tick();

        // 1: write 0x82 / 0x5A
        dev_status = 2'b01;
        rx_ready = 1'b1;
        host_byte("t1_code", 8'h82);
        pa_in = 8'h5A;
        dav_in = 1'b1;
        wait_ack("t1_data_ack1", 1'b1);
        check_eq("t1_rx_data", 16'(rx_seen), 16'h5A);
        check_eq("t1_rx_cmd", 16'(rx_cmd_seen), 16'd0);
        check_eq("t1_rx_cnt", 16'(rx_cnt), 16'd1);
        check_eq("t1_status", 16'(status_out), 16'h1);
        check_eq("t1_settle", 16'(ack_since), 16'(SETTLE));
        dav_in = 1'b0;
        wait_ack("t1_data_ack0", 1'b0);

        // 2: cmd 0x81 / 0x28 with rx_ready held low for 50 clocks
        rx_ready = 1'b0;
        host_byte("t2_code", 8'h81);
        pa_in = 8'h28;
        dav_in = 1'b1;
        n = 0;
        while (!rx_valid && n < 50) begin tick(); n++; end
        check_eq("t2_rxv", 16'(rx_valid), 16'd1);
        hi = 0;
        repeat (50) begin tick(); if (ack_out) hi++; end
        check_eq("t2_ack_held", 16'(hi), 16'd0);
        check_eq("t2_rxv_held", 16'(rx_valid), 16'd1);
        rx_ready = 1'b1;
        wait_ack("t2_ack1", 1'b1);
        check_eq("t2_rx_data", 16'(rx_seen), 16'h28);
        check_eq("t2_rx_cmd", 16'(rx_cmd_seen), 16'd1);
        check_eq("t2_no_to", 16'(et_cnt), 16'd0);
        dav_in = 1'b0;
        wait_ack("t2_ack0", 1'b0);

        // 3: read 0x83 -> 0xC3 / status 2'b10
        tx_valid = 1'b1;
        tx_data = 8'hC3;
        tx_status = 2'b10;
        host_byte("t3_code", 8'h83);
        pa_in = 8'h00;
        dav_in = 1'b1;
        n = 0;
        while (!pa_oe && n < 50) begin tick(); n++; end
        check_eq("t3_oe", 16'(pa_oe), 16'd1);
        check_eq("t3_pa", 16'(pa_out), 16'hC3);
        check_eq("t3_st", 16'(status_out), 16'h2);
        tx_valid = 1'b0;
        wait_ack("t3_ack1", 1'b1);
        check_eq("t3_settle", 16'(ack_since), 16'(SETTLE));
        check_eq("t3_txr", 16'(tx_cnt), 16'd1);
        dav_in = 1'b0;
        wait_ack("t3_ack0", 1'b0);
        check_eq("t3_oe_off", 16'(pa_oe), 16'd0);

        // 4: unknown code 0x55
        n = rx_cnt;
        host_byte("t4_code", 8'h55);
        check_eq("t4_err", 16'(ec_cnt), 16'd1);
        check_eq("t4_st", 16'(status_out), 16'h3);
        check_eq("t4_settle", 16'(ack_since), 16'(SETTLE));
        repeat (5) tick();
        check_eq("t4_no_rx", 16'(rx_cnt), 16'(n));
        check_eq("t4_idle", 16'({ack_out, pa_oe, rx_valid}), 16'd0);

        // 5: 0x82 code, then host never raises DAV
        host_byte("t5_code", 8'h82);
        n = 0;
        while (!err_timeout && n < 200) begin tick(); n++; end
        check_eq("t5_to_lat", 16'(n), 16'(TIMEOUT));
        check_eq("t5_to_cnt", 16'(et_cnt), 16'd1);
        check_eq("t5_idle", 16'({ack_out, pa_oe, rx_valid}), 16'd0);
        repeat (3) tick();

        // 6: reset during TX_SET with DAV held high
        tx_valid = 1'b1;
        tx_data = 8'h3C;
        tx_status = 2'b01;
        host_byte("t6_code", 8'h83);
        dav_in = 1'b1;
        n = 0;
        while (!pa_oe && n < 50) begin tick(); n++; end
        check_eq("t6_oe", 16'(pa_oe), 16'd1);
        tx_valid = 1'b0;
        tick();
        reset = 1'b1;
        pa_in = 8'h55;
        tick();
        check_eq("t6_rst_oe", 16'(pa_oe), 16'd0);
        check_eq("t6_rst_ack", 16'(ack_out), 16'd0);
        check_eq("t6_rst_pa", 16'(pa_out), 16'h0);
        tick();
        reset = 1'b0;
        ec0 = ec_cnt;
        hi = 0;
        repeat (20) begin tick(); if (ack_out) hi++; end
        check_eq("t6_no_ack", 16'(hi), 16'd0);
        check_eq("t6_no_code", 16'(ec_cnt), 16'(ec0));
        check_eq("t6_st", 16'(status_out), 16'h0);
        dav_in = 1'b0;
        repeat (5) tick();
        host_byte("t6_new", 8'h55);
        check_eq("t6_new_err", 16'(ec_cnt), 16'(ec0 + 1));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
